// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a five-stage pipeline. A private two-entry shadow scoreboard
// tracks the destinations in EXE and MEM, so no taps into downstream stage registers are needed.
module pipeline_hazard_ctrl #(
  parameter bit          FORWARD  = 1'b0,
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        id_valid_i,
  input  logic [3:0]  id_src1_i,
  input  logic [3:0]  id_src2_i,
  input  logic        id_src1_used_i,
  input  logic        id_src2_used_i,
  input  logic        id_wb_en_i,
  input  logic [3:0]  id_dest_i,
  input  logic        id_mem_read_i,
  input  logic        id_mem_write_i,
  input  logic        exe_branch_taken_i,
  output logic        freeze_o,
  output logic        flush_o,
  output logic        bubble_o,
  output logic        stall_all_o,
  output logic [15:0] stall_cnt_o
);

  typedef struct packed {
    logic       valid;
    logic       wb_en;
    logic [3:0] dest;
    logic       mem_rd;
    logic       mem_acc;
  } sb_entry_t;

  localparam logic [3:0] WaitLoad = 4'(MEM_WAIT);

  sb_entry_t   exe_q, exe_d, mem_q, mem_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        exe_wr, mem_wr;
  logic        src1_hit, src2_hit;
  logic        hazard, stall_all, flush, bubble, freeze;

  // With forwarding only a load still in EXE cannot be bypassed in time.
  always_comb begin
    exe_wr   = exe_q.valid & exe_q.wb_en & (FORWARD ? exe_q.mem_rd : 1'b1);
    mem_wr   = mem_q.valid & mem_q.wb_en & ~FORWARD;
    src1_hit = id_src1_used_i & ((exe_wr & (id_src1_i == exe_q.dest)) |
                                 (mem_wr & (id_src1_i == mem_q.dest)));
    src2_hit = id_src2_used_i & ((exe_wr & (id_src2_i == exe_q.dest)) |
                                 (mem_wr & (id_src2_i == mem_q.dest)));
    hazard   = id_valid_i & (src1_hit | src2_hit);
  end

  always_comb begin
    stall_all   = (wcnt_q != 4'd0);
    flush       = exe_branch_taken_i & ~stall_all;
    bubble      = hazard & ~stall_all & ~flush;
    freeze      = stall_all | bubble;

    exe_d       = exe_q;
    mem_d       = mem_q;
    wcnt_d      = wcnt_q;
    stall_cnt_d = stall_cnt_q;

    if (freeze && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    if (!stall_all) begin
      mem_d = exe_q;
      exe_d = '0;
      if (id_valid_i && !hazard && !flush) begin
        exe_d.valid   = 1'b1;
        exe_d.wb_en   = id_wb_en_i;
        exe_d.dest    = id_dest_i;
        exe_d.mem_rd  = id_mem_read_i;
        exe_d.mem_acc = id_mem_read_i | id_mem_write_i;
      end
      // A memory access moving into MEM holds the whole pipe for MEM_WAIT cycles.
      if (exe_q.valid && exe_q.mem_acc) begin
        wcnt_d = WaitLoad;
      end
    end else begin
      wcnt_d = wcnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exe_q       <= '0;
      mem_q       <= '0;
      wcnt_q      <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      exe_q       <= exe_d;
      mem_q       <= mem_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign freeze_o    = freeze;
  assign flush_o     = flush;
  assign bubble_o    = bubble;
  assign stall_all_o = stall_all;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations share stimulus and are checked every
// cycle against a behavioural model, plus directed scenarios with literal expectations.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, s1u, s2u, wb, rd, wr, br;
  logic [3:0] s1, s2, dest;

  logic        freeze_w [2];
  logic        flush_w  [2];
  logic        bubble_w [2];
  logic        stall_w  [2];
  logic [15:0] scnt_w   [2];

  int n_cmp = 0;
  int n_err = 0;
  bit run_cmp = 1'b0;

  // Instance 0: no forwarding, 3 wait cycles. Instance 1: forwarding, 2 wait cycles.
  pipeline_hazard_ctrl #(.FORWARD(1'b0), .MEM_WAIT(3)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_src1_i(s1), .id_src2_i(s2),
    .id_src1_used_i(s1u), .id_src2_used_i(s2u), .id_wb_en_i(wb), .id_dest_i(dest),
    .id_mem_read_i(rd), .id_mem_write_i(wr), .exe_branch_taken_i(br),
    .freeze_o(freeze_w[0]), .flush_o(flush_w[0]), .bubble_o(bubble_w[0]),
    .stall_all_o(stall_w[0]), .stall_cnt_o(scnt_w[0])
  );

  pipeline_hazard_ctrl #(.FORWARD(1'b1), .MEM_WAIT(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_src1_i(s1), .id_src2_i(s2),
    .id_src1_used_i(s1u), .id_src2_used_i(s2u), .id_wb_en_i(wb), .id_dest_i(dest),
    .id_mem_read_i(rd), .id_mem_write_i(wr), .exe_branch_taken_i(br),
    .freeze_o(freeze_w[1]), .flush_o(flush_w[1]), .bubble_o(bubble_w[1]),
    .stall_all_o(stall_w[1]), .stall_cnt_o(scnt_w[1])
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit v;
    bit wb;
    int dest;
    bit ld;
    bit mem;
  } slot_t;

  slot_t m_ex [2];
  slot_t m_mm [2];
  int    m_wait [2];
  int    m_scnt [2];

  function automatic bit fwd_of(input int c);
    return c == 1;
  endfunction

  function automatic int mw_of(input int c);
    return (c == 0) ? 3 : 2;
  endfunction

  function automatic bit m_hazard(input int c);
    bit hit = 1'b0;
    if (!id_valid) return 1'b0;
    for (int k = 0; k < 2; k++) begin
      slot_t e = (k == 0) ? m_ex[c] : m_mm[c];
      bit producer = e.v && e.wb && (fwd_of(c) ? (k == 0 && e.ld) : 1'b1);
      if (producer && ((s1u && int'(s1) == e.dest) || (s2u && int'(s2) == e.dest))) hit = 1'b1;
    end
    return hit;
  endfunction

  task automatic m_outputs(input int c, output bit fz, output bit fl, output bit bb,
                           output bit st);
    st = (m_wait[c] != 0);
    fl = br && !st;
    bb = m_hazard(c) && !st && !fl;
    fz = st || bb;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        m_ex[c]   = '{0, 0, 0, 0, 0};
        m_mm[c]   = '{0, 0, 0, 0, 0};
        m_wait[c] = 0;
        m_scnt[c] = 0;
      end else begin
        bit fz, fl, bb, st, hz;
        m_outputs(c, fz, fl, bb, st);
        hz = m_hazard(c);
        if (fz && m_scnt[c] < 65535) m_scnt[c] = m_scnt[c] + 1;
        if (st) begin
          m_wait[c] = m_wait[c] - 1;
        end else begin
          m_wait[c] = (m_ex[c].v && m_ex[c].mem) ? mw_of(c) : 0;
          m_mm[c]   = m_ex[c];
          if (id_valid && !hz && !fl) m_ex[c] = '{1, wb, int'(dest), rd, rd || wr};
          else m_ex[c] = '{0, 0, 0, 0, 0};
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are stable mid-cycle.
  initial forever begin
    @(negedge clk);
    if (run_cmp && rst_n) begin
      for (int c = 0; c < 2; c++) begin
        bit fz, fl, bb, st;
        m_outputs(c, fz, fl, bb, st);
        chk($sformatf("dut%0d freeze", c), int'(freeze_w[c]), int'(fz));
        chk($sformatf("dut%0d flush", c), int'(flush_w[c]), int'(fl));
        chk($sformatf("dut%0d bubble", c), int'(bubble_w[c]), int'(bb));
        chk($sformatf("dut%0d stall_all", c), int'(stall_w[c]), int'(st));
        chk($sformatf("dut%0d stall_cnt", c), int'(scnt_w[c]), m_scnt[c]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nop();
    id_valid = 1'b0; s1 = 4'd0; s2 = 4'd0; s1u = 1'b0; s2u = 1'b0;
    wb = 1'b0; dest = 4'd0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic ins(input logic [3:0] a, input bit au, input logic [3:0] b, input bit bu,
                     input bit w, input logic [3:0] d, input bit r, input bit wrr);
    id_valid = 1'b1; s1 = a; s1u = au; s2 = b; s2u = bu;
    wb = w; dest = d; rd = r; wr = wrr;
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    nxt();
    rst_n = 1'b0;
    nop();
    br = 1'b0;
    #4;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nop();
    br = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
    run_cmp = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("reset stall_all", int'(stall_w[c]), 0);
      chk("reset stall_cnt", int'(scnt_w[c]), 0);
      chk("reset freeze", int'(freeze_w[c]), 0);
      chk("reset flush", int'(flush_w[c]), 0);
      chk("reset bubble", int'(bubble_w[c]), 0);
    end

    // RAW without forwarding; non-load producer with forwarding never stalls.
    do_reset();
    nxt(); ins(4'd0, 0, 4'd0, 0, 1, 4'd1, 0, 0); #1;
    chk("raw A freeze0", int'(freeze_w[0]), 0);
    nxt(); ins(4'd1, 1, 4'd0, 0, 1, 4'd2, 0, 0); #1;
    chk("raw B freeze0", int'(freeze_w[0]), 1);
    chk("raw B bubble0", int'(bubble_w[0]), 1);
    chk("raw B freeze1", int'(freeze_w[1]), 0);
    nxt(); #1;
    chk("raw C freeze0", int'(freeze_w[0]), 1);
    chk("raw C bubble0", int'(bubble_w[0]), 1);
    nxt(); #1;
    chk("raw D freeze0", int'(freeze_w[0]), 0);
    chk("raw D stall_cnt0", int'(scnt_w[0]), 2);
    chk("raw D stall_cnt1", int'(scnt_w[1]), 0);

    // Load-use with forwarding.
    do_reset();
    nxt(); ins(4'd0, 0, 4'd0, 0, 1, 4'd3, 1, 0); #1;
    chk("lu A freeze1", int'(freeze_w[1]), 0);
    nxt(); ins(4'd0, 0, 4'd3, 1, 1, 4'd4, 0, 0); #1;
    chk("lu B freeze1", int'(freeze_w[1]), 1);
    chk("lu B bubble1", int'(bubble_w[1]), 1);
    nxt(); #1;
    chk("lu C bubble1", int'(bubble_w[1]), 0);
    chk("lu C stall1", int'(stall_w[1]), 1);
    nxt(); #1;
    chk("lu D stall1", int'(stall_w[1]), 1);
    nxt(); #1;
    chk("lu E stall1", int'(stall_w[1]), 0);
    chk("lu E freeze1", int'(freeze_w[1]), 0);
    chk("lu E stall_cnt1", int'(scnt_w[1]), 3);

    // Branch beats hazard; squashed instruction never enters the scoreboard.
    do_reset();
    nxt(); ins(4'd0, 0, 4'd0, 0, 1, 4'd1, 0, 0);
    nxt(); ins(4'd1, 1, 4'd0, 0, 1, 4'd6, 0, 0); br = 1'b1; #1;
    chk("br B flush0", int'(flush_w[0]), 1);
    chk("br B freeze0", int'(freeze_w[0]), 0);
    chk("br B bubble0", int'(bubble_w[0]), 0);
    chk("br B flush1", int'(flush_w[1]), 1);
    nxt(); br = 1'b0; ins(4'd6, 1, 4'd0, 0, 1, 4'd7, 0, 0); #1;
    chk("br C freeze0", int'(freeze_w[0]), 0);
    chk("br C freeze1", int'(freeze_w[1]), 0);
    chk("br C flush0", int'(flush_w[0]), 0);

    // Memory wait and deferred branch.
    do_reset();
    nxt(); ins(4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1); #1;
    chk("mw A stall0", int'(stall_w[0]), 0);
    nxt(); nop(); #1;
    chk("mw B stall0", int'(stall_w[0]), 0);
    chk("mw B stall1", int'(stall_w[1]), 0);
    nxt(); br = 1'b1; #1;
    chk("mw C stall0", int'(stall_w[0]), 1);
    chk("mw C stall1", int'(stall_w[1]), 1);
    chk("mw C flush0", int'(flush_w[0]), 0);
    chk("mw C flush1", int'(flush_w[1]), 0);
    nxt(); #1;
    chk("mw D stall0", int'(stall_w[0]), 1);
    chk("mw D stall1", int'(stall_w[1]), 1);
    chk("mw D flush1", int'(flush_w[1]), 0);
    nxt(); #1;
    chk("mw E stall0", int'(stall_w[0]), 1);
    chk("mw E stall1", int'(stall_w[1]), 0);
    chk("mw E flush0", int'(flush_w[0]), 0);
    chk("mw E flush1", int'(flush_w[1]), 1);
    chk("mw E stall_cnt1", int'(scnt_w[1]), 2);
    nxt(); #1;
    chk("mw F stall0", int'(stall_w[0]), 0);
    chk("mw F flush0", int'(flush_w[0]), 1);
    chk("mw F freeze0", int'(freeze_w[0]), 0);
    chk("mw F stall_cnt0", int'(scnt_w[0]), 3);
    nxt(); br = 1'b0;

    // Reset in the middle of a memory wait.
    do_reset();
    nxt(); ins(4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1);
    nxt(); nop();
    nxt();
    nxt(); #1;
    chk("rs D stall_cnt0", int'(scnt_w[0]), 1);
    chk("rs D stall_cnt1", int'(scnt_w[1]), 1);
    chk("rs D stall0", int'(stall_w[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("rs async stall_all", int'(stall_w[c]), 0);
      chk("rs async stall_cnt", int'(scnt_w[c]), 0);
    end
    #1 rst_n = 1'b1;
    nxt(); ins(4'd0, 1, 4'd5, 1, 1, 4'd0, 0, 0); #1;
    chk("rs E freeze0", int'(freeze_w[0]), 0);
    chk("rs E freeze1", int'(freeze_w[1]), 0);

    // Randomized traffic over a small register window to provoke frequent hazards.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      nxt();
      id_valid = ($urandom_range(0, 3) != 0);
      s1   = 4'($urandom_range(0, 3));
      s2   = 4'($urandom_range(0, 3));
      s1u  = 1'($urandom_range(0, 1));
      s2u  = 1'($urandom_range(0, 1));
      wb   = 1'($urandom_range(0, 1));
      dest = 4'($urandom_range(0, 3));
      rd   = ($urandom_range(0, 4) == 0);
      wr   = ($urandom_range(0, 6) == 0);
      br   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    nxt();
    nop();
    br = 1'b0;
    nxt();
    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage ARM pipeline (IF, ID, EXE, MEM, WB). It takes the operand/destination summary of the instruction currently in ID, the taken-branch signal from EXE, and memory-access flags. From these it drives the `freeze` and `flush` nets that the IF stage and the IF/ID pipeline registers consume, plus a `bubble` control for the ID/EXE register and a whole-pipe `stall_all`. It keeps its own shadow scoreboard of the destinations in EXE and MEM, so it needs no taps into the downstream stage registers.

## Interface
- `FORWARD`, default 0: 0 = no forwarding, stall on any RAW against EXE or MEM; 1 = forwarding present, stall only on load-use against EXE.
- `MEM_WAIT`, default 0: extra cycles each memory access holds the whole pipe (0..15).
- `clk` in 1: the only clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_src1`, `id_src2` in 4 each: source register numbers.
- `id_src1_used`, `id_src2_used` in 1 each: the corresponding source is read.
- `id_wb_en` in 1: the ID instruction writes `id_dest`.
- `id_dest` in 4: destination register.
- `id_mem_read`, `id_mem_write` in 1 each: the ID instruction is a load or a store.
- `exe_branch_taken` in 1: the branch in EXE resolved taken this cycle.
- `freeze` out 1: hold the PC and the IF/ID register.
- `flush` out 1: clear the IF/ID register and squash the ID instruction.
- `bubble` out 1: the ID/EXE register loads a NOP this cycle.
- `stall_all` out 1: hold every pipeline register (memory wait).
- `stall_cnt` out 16: saturating count of cycles with `freeze`=1.

## Operation
- Shadow scoreboard has two entries, EXE and MEM. Each entry holds {valid, wb_en, dest[3:0], mem_rd, mem_acc}.
- Hazard (combinational) requires `id_valid`. Then, for each used source s:
  - `FORWARD`=0: s==EXE.dest with EXE.valid&wb_en, or s==MEM.dest with MEM.valid&wb_en.
  - `FORWARD`=1: s==EXE.dest with EXE.valid&wb_en&mem_rd.
- Output equations:
  - `flush` = `exe_branch_taken` & ~`stall_all`.
  - `bubble` = hazard & ~`stall_all` & ~`flush`.
  - `freeze` = `stall_all` | `bubble`.
- Branch priority: flush beats hazard, so `freeze`=0 and IF loads the branch target.
- Scoreboard update when `stall_all`=0:
  - MEM <= EXE.
  - EXE <= ID info if `id_valid` & ~hazard & ~`flush`, else an invalid entry.
- Scoreboard update when `stall_all`=1: both entries hold.
- Memory-wait counter `wcnt` (4 bit), `stall_all` = (`wcnt`!=0):
  - Loads `MEM_WAIT` on the edge where EXE.mem_acc (valid) shifts into MEM.
  - Otherwise decrements while nonzero.
- `stall_cnt` increments on every edge where `freeze`=1 and saturates at 16'hFFFF.
- Reset (`rst`=0, asynchronous) clears:
  - both scoreboard entries to invalid;
  - `wcnt` and `stall_cnt` to 0.
- Outputs after reset: `stall_all`=0 and `stall_cnt`=0. `freeze`, `flush` and `bubble` depend only on inputs and are 0 with `id_valid`=0 and `exe_branch_taken`=0.
- Reset mid-stall ends the stall immediately, asynchronously.

## Timing
- All outputs are combinational from current inputs plus registered state. They are valid in the same cycle; there are no extra latency stages.
- Single RAW at `FORWARD`=0:
  - Producer in EXE → `freeze` for 2 cycles.
  - Producer in MEM → `freeze` for 1 cycle.
- Load-use at `FORWARD`=1 → exactly 1 `freeze` cycle.
- A taken branch gives `flush` for exactly 1 cycle. The squashed ID instruction never enters the scoreboard.
- A memory access gives `stall_all` for exactly `MEM_WAIT` cycles, starting the cycle after it enters MEM. With `MEM_WAIT`=0 it never stalls.
- A branch arriving during `stall_all` is deferred. `flush` asserts on the first cycle with `stall_all`=0, while `exe_branch_taken` is still held.
- Back-to-back memory accesses: the second reloads `wcnt` only after the first finishes, since the pipe is held meanwhile.
- Register r0 gets no special treatment; all 16 registers are tracked.

## Test plan
- **RAW stall, no forwarding.** `FORWARD`=0. Issue ADD r1 (wb_en, dest=1), then SUB using src1=1. Required: `freeze`=`bubble`=1 for 2 cycles, then 0; `stall_cnt`=2.
- **Load-use, forwarding.** `FORWARD`=1. Issue LDR r3, then ADD with src2=3. Required: 1 cycle of `freeze`/`bubble`. A non-load producer into r3 gives 0 stall cycles.
- **Branch vs hazard.** Hold a hazard in ID while `exe_branch_taken`=1. Required in that cycle: `flush`=1, `freeze`=0, `bubble`=0. The next cycle's EXE entry is invalid, so the following ID reading r1 is not stalled by the squashed instruction.
- **Memory wait.** `MEM_WAIT`=3, one STR. Required: `stall_all`=1 for 3 cycles, starting the cycle after the STR reaches MEM. Scoreboard is unchanged across those cycles; `stall_cnt`=3.
- **Deferred branch.** `MEM_WAIT`=2. Assert `exe_branch_taken` while `stall_all`=1. Required: `flush`=0 during the stall, `flush`=1 on the first free cycle.
- **Reset mid-stall.** Drive `rst`=0 in the middle of the memory wait. Required: `stall_all` and `stall_cnt` go to 0 immediately (asynchronously); no hazard after release with `id_valid`=1.
